// File: rtl/div_unit_lock_manager_if.sv
// Handshake bundle between mem issue / writeback / recovery and the divider lock manager.
// The master drives the requests; the slave (lock manager) reports per-unit status.
interface div_unit_lock_manager_if #(
    parameter int NUM_UNITS    = 2,
    parameter int AL_PTR_WIDTH = 6
);
    logic [NUM_UNITS-1:0]                   acquire;
    logic [NUM_UNITS-1:0][AL_PTR_WIDTH-1:0] acquireActiveListPtr;
    logic [NUM_UNITS-1:0]                   start;
    // "release" is a reserved word, hence the suffix
    logic [NUM_UNITS-1:0]                   releaseUnit;
    logic                                   toRecoveryPhase;
    logic [AL_PTR_WIDTH-1:0]                flushRangeHeadPtr;
    logic [AL_PTR_WIDTH-1:0]                flushRangeTailPtr;
    logic                                   flushAllInsns;
    logic [NUM_UNITS-1:0]                   free;
    logic [NUM_UNITS-1:0]                   busy;
    logic [NUM_UNITS-1:0]                   finished;
    logic [NUM_UNITS-1:0][AL_PTR_WIDTH-1:0] ownerActiveListPtr;
    logic                                   protocolError;

    modport master (
        output acquire, acquireActiveListPtr, start, releaseUnit,
               toRecoveryPhase, flushRangeHeadPtr, flushRangeTailPtr, flushAllInsns,
        input  free, busy, finished, ownerActiveListPtr, protocolError
    );

    modport slave (
        input  acquire, acquireActiveListPtr, start, releaseUnit,
               toRecoveryPhase, flushRangeHeadPtr, flushRangeTailPtr, flushAllInsns,
        output free, busy, finished, ownerActiveListPtr, protocolError
    );
endinterface

// File: rtl/div_unit_lock_manager.sv
// Ownership and progress tracker for the shared divider units: each unit walks
// FREE -> RESERVED -> COMPUTING -> FINISHED -> FREE, with recovery flushes returning it early.
module div_unit_lock_manager #(
    parameter int NUM_UNITS    = 2,
    parameter int AL_PTR_WIDTH = 6,
    parameter int DIV_LATENCY  = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    div_unit_lock_manager_if.slave   bus
);
    localparam int CNT_W = $clog2(DIV_LATENCY);

    typedef logic [CNT_W-1:0]        cnt_t;
    typedef logic [AL_PTR_WIDTH-1:0] ptr_t;

    typedef enum logic [1:0] {
        UNIT_FREE,
        UNIT_RESERVED,
        UNIT_COMPUTING,
        UNIT_FINISHED
    } unit_state_e;

    unit_state_e state_q [NUM_UNITS];
    unit_state_e state_d [NUM_UNITS];
    cnt_t        count_q [NUM_UNITS];
    cnt_t        count_d [NUM_UNITS];
    ptr_t        owner_q [NUM_UNITS];
    ptr_t        owner_d [NUM_UNITS];
    logic        flush_hit [NUM_UNITS];
    logic        error_q;
    logic        error_d;

    // Circular [head, tail) membership; an empty range (head == tail) matches nothing
    function automatic logic in_flush_range(input ptr_t p, input ptr_t head, input ptr_t tail);
        logic hit;
        if (head < tail)
            hit = (p >= head) && (p < tail);
        else if (head > tail)
            hit = (p >= head) || (p < tail);
        else
            hit = 1'b0;
        return hit;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= UNIT_FREE;
                count_q[i] <= '0;
                owner_q[i] <= '0;
            end
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                owner_q[i] <= owner_d[i];
            end
            error_q <= error_d;
        end
    end

    // A flush hit on an owned unit overrides every other event, including its errors
    always_comb begin
        error_d = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            state_d[i]   = state_q[i];
            count_d[i]   = count_q[i];
            owner_d[i]   = owner_q[i];
            flush_hit[i] = bus.toRecoveryPhase &&
                           (bus.flushAllInsns ||
                            in_flush_range(owner_q[i], bus.flushRangeHeadPtr, bus.flushRangeTailPtr));
            if (state_q[i] != UNIT_FREE && flush_hit[i]) begin
                state_d[i] = UNIT_FREE;
                count_d[i] = '0;
            end else begin
                case (state_q[i])
                    UNIT_FREE: begin
                        if (bus.acquire[i]) begin
                            state_d[i] = UNIT_RESERVED;
                            owner_d[i] = bus.acquireActiveListPtr[i];
                        end
                        if (bus.start[i] || bus.releaseUnit[i])
                            error_d = 1'b1;
                    end
                    UNIT_RESERVED: begin
                        if (bus.start[i]) begin
                            state_d[i] = UNIT_COMPUTING;
                            count_d[i] = cnt_t'(DIV_LATENCY - 1);
                        end
                        if (bus.acquire[i])
                            error_d = 1'b1;
                    end
                    UNIT_COMPUTING: begin
                        // Leaving as the counter steps to zero gives DIV_LATENCY-1 busy cycles
                        count_d[i] = count_q[i] - cnt_t'(1);
                        if (count_q[i] == cnt_t'(1))
                            state_d[i] = UNIT_FINISHED;
                        if (bus.releaseUnit[i])
                            error_d = 1'b1;
                    end
                    UNIT_FINISHED: begin
                        if (bus.releaseUnit[i])
                            state_d[i] = UNIT_FREE;
                    end
                    default: begin
                        state_d[i] = UNIT_FREE;
                        count_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.free               = '0;
        bus.busy               = '0;
        bus.finished           = '0;
        bus.ownerActiveListPtr = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            bus.free[i]               = (state_q[i] == UNIT_FREE);
            bus.busy[i]               = (state_q[i] == UNIT_COMPUTING);
            bus.finished[i]           = (state_q[i] == UNIT_FINISHED);
            bus.ownerActiveListPtr[i] = owner_q[i];
        end
        bus.protocolError = error_q;
    end
endmodule

// File: tb/tb_div_unit_lock_manager.sv
// Self-checking bench: a timestamp-based ownership model is compared against the lock
// manager every cycle, with directed scenarios pinning key cycles to literal values.
module tb_div_unit_lock_manager;
    localparam int NU = 2;
    localparam int W  = 6;
    localparam int L  = 34;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_lock_manager_if #(.NUM_UNITS(NU), .AL_PTR_WIDTH(W)) bus ();

    div_unit_lock_manager #(.NUM_UNITS(NU), .AL_PTR_WIDTH(W), .DIV_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: a unit is owned or not; once started it is busy until doneAt, then finished
    bit           mOwned   [NU];
    bit           mStarted [NU];
    int           mDoneAt  [NU];
    logic [W-1:0] mPtr     [NU];
    bit           mErr;
    int           cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    function automatic bit inRange(input logic [W-1:0] p, input logic [W-1:0] h, input logic [W-1:0] t);
        int m = 1 << W;
        return ((int'(p) - int'(h) + m) % m) < ((int'(t) - int'(h) + m) % m);
    endfunction

    always @(posedge clk) begin
        bit errNow;
        bit hit;
        if (rst) begin
            for (int i = 0; i < NU; i++) begin
                mOwned[i] = 0; mStarted[i] = 0; mDoneAt[i] = 0; mPtr[i] = '0;
            end
            mErr = 0;
        end else begin
            errNow = 0;
            for (int i = 0; i < NU; i++) begin
                hit = bus.toRecoveryPhase &&
                      (bus.flushAllInsns || inRange(mPtr[i], bus.flushRangeHeadPtr, bus.flushRangeTailPtr));
                if (!mOwned[i]) begin
                    if (bus.acquire[i]) begin
                        mOwned[i] = 1; mStarted[i] = 0; mPtr[i] = bus.acquireActiveListPtr[i];
                    end
                    if (bus.start[i] || bus.releaseUnit[i]) errNow = 1;
                end else if (hit) begin
                    mOwned[i] = 0; mStarted[i] = 0;
                end else if (!mStarted[i]) begin
                    if (bus.start[i]) begin
                        mStarted[i] = 1; mDoneAt[i] = cyc + L;
                    end
                    if (bus.acquire[i]) errNow = 1;
                end else if (cyc < mDoneAt[i]) begin
                    if (bus.releaseUnit[i]) errNow = 1;
                end else if (bus.releaseUnit[i]) begin
                    mOwned[i] = 0; mStarted[i] = 0;
                end
            end
            mErr = errNow;
        end
        cyc++;
        #1;
        for (int i = 0; i < NU; i++) begin
            checkOutput($sformatf("free[%0d]", i), 32'(bus.free[i]), 32'(!mOwned[i]));
            checkOutput($sformatf("busy[%0d]", i), 32'(bus.busy[i]),
                        32'(mOwned[i] && mStarted[i] && cyc < mDoneAt[i]));
            checkOutput($sformatf("finished[%0d]", i), 32'(bus.finished[i]),
                        32'(mOwned[i] && mStarted[i] && cyc >= mDoneAt[i]));
            checkOutput($sformatf("owner[%0d]", i), 32'(bus.ownerActiveListPtr[i]), 32'(mPtr[i]));
        end
        checkOutput("protocolError", 32'(bus.protocolError), 32'(mErr));
    end

    task automatic clearInputs();
        rst                      = 1'b0;
        bus.acquire              = '0;
        bus.acquireActiveListPtr = '0;
        bus.start                = '0;
        bus.releaseUnit          = '0;
        bus.toRecoveryPhase      = 1'b0;
        bus.flushRangeHeadPtr    = '0;
        bus.flushRangeTailPtr    = '0;
        bus.flushAllInsns        = 1'b0;
    endtask

    // One clock: inputs set beforehand are sampled, then everything returns to idle
    task automatic applyStimulus();
        @(posedge clk);
        #2;
        clearInputs();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus();
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("resetFree", 32'(bus.free), 32'h3);
        checkOutput("resetBusy", 32'(bus.busy), 32'h0);
        checkOutput("resetFinished", 32'(bus.finished), 32'h0);
        checkOutput("resetOwner", 32'(bus.ownerActiveListPtr), 32'h0);
        checkOutput("resetError", 32'(bus.protocolError), 32'h0);
        clearInputs();

        // Basic sequence, owner pointer 5
        bus.acquire[0] = 1'b1; bus.acquireActiveListPtr[0] = 6'd5;
        applyStimulus();
        checkOutput("basicAcqFree", 32'(bus.free[0]), 32'h0);
        checkOutput("basicOwner", 32'(bus.ownerActiveListPtr[0]), 32'h5);
        applyStimulus();
        bus.start[0] = 1'b1;
        applyStimulus();
        checkOutput("basicBusyFirst", 32'(bus.busy[0]), 32'h1);
        idle(32);
        checkOutput("basicBusyLast", 32'(bus.busy[0]), 32'h1);
        checkOutput("basicNotFinYet", 32'(bus.finished[0]), 32'h0);
        applyStimulus();
        checkOutput("basicFinished", 32'(bus.finished[0]), 32'h1);
        checkOutput("basicBusyDrop", 32'(bus.busy[0]), 32'h0);
        idle(4);
        bus.releaseUnit[0] = 1'b1;
        applyStimulus();
        checkOutput("basicReleased", 32'(bus.free[0]), 32'h1);

        // Wrapping flush range [60, 3)
        bus.acquire = 2'b11;
        bus.acquireActiveListPtr[0] = 6'd62; bus.acquireActiveListPtr[1] = 6'd10;
        applyStimulus();
        bus.start = 2'b11;
        applyStimulus();
        idle(5);
        bus.toRecoveryPhase = 1'b1; bus.flushRangeHeadPtr = 6'd60; bus.flushRangeTailPtr = 6'd3;
        applyStimulus();
        checkOutput("wrapFlushedFree", 32'(bus.free[0]), 32'h1);
        checkOutput("wrapSurvivorBusy", 32'(bus.busy[1]), 32'h1);
        idle(L - 8);
        checkOutput("wrapStillBusy", 32'(bus.busy[1]), 32'h1);
        applyStimulus();
        checkOutput("wrapFinished", 32'(bus.finished[1]), 32'h1);
        bus.releaseUnit[1] = 1'b1;
        applyStimulus();
        checkOutput("wrapAllFree", 32'(bus.free), 32'h3);

        // Empty range: flushAll decides alone
        for (int pass = 0; pass < 2; pass++) begin
            bus.acquire = 2'b11;
            bus.acquireActiveListPtr[0] = 6'd7; bus.acquireActiveListPtr[1] = 6'd20;
            applyStimulus();
            bus.start = 2'b11;
            applyStimulus();
            idle(L - 1);
            checkOutput("emptyBothFinished", 32'(bus.finished), 32'h3);
            bus.toRecoveryPhase = 1'b1; bus.flushAllInsns = (pass == 0);
            bus.flushRangeHeadPtr = 6'd7; bus.flushRangeTailPtr = 6'd7;
            applyStimulus();
            checkOutput("emptyFlushFree", 32'(bus.free), (pass == 0) ? 32'h3 : 32'h0);
        end
        bus.releaseUnit = 2'b11;
        applyStimulus();

        // Flush beats start in RESERVED; release plus flush in FINISHED is clean
        bus.acquire[0] = 1'b1; bus.acquireActiveListPtr[0] = 6'd33;
        applyStimulus();
        bus.start[0] = 1'b1; bus.toRecoveryPhase = 1'b1; bus.flushAllInsns = 1'b1;
        applyStimulus();
        checkOutput("prioStartFree", 32'(bus.free[0]), 32'h1);
        checkOutput("prioStartBusy", 32'(bus.busy[0]), 32'h0);
        applyStimulus();
        checkOutput("prioStartBusyLater", 32'(bus.busy[0]), 32'h0);
        bus.acquire[0] = 1'b1; bus.acquireActiveListPtr[0] = 6'd33;
        applyStimulus();
        bus.start[0] = 1'b1;
        applyStimulus();
        idle(L - 1);
        bus.releaseUnit[0] = 1'b1; bus.toRecoveryPhase = 1'b1; bus.flushAllInsns = 1'b1;
        applyStimulus();
        checkOutput("prioRelFree", 32'(bus.free[0]), 32'h1);
        checkOutput("prioRelNoError", 32'(bus.protocolError), 32'h0);

        // Illegal events pulse protocolError for one cycle
        bus.start[0] = 1'b1;
        applyStimulus();
        checkOutput("illegalStartError", 32'(bus.protocolError), 32'h1);
        checkOutput("illegalStartFree", 32'(bus.free[0]), 32'h1);
        applyStimulus();
        checkOutput("illegalStartPulse", 32'(bus.protocolError), 32'h0);
        bus.acquire[0] = 1'b1; bus.acquireActiveListPtr[0] = 6'd12;
        applyStimulus();
        bus.acquire[0] = 1'b1; bus.acquireActiveListPtr[0] = 6'd40;
        applyStimulus();
        checkOutput("illegalAcqError", 32'(bus.protocolError), 32'h1);
        checkOutput("illegalAcqOwner", 32'(bus.ownerActiveListPtr[0]), 32'd12);
        applyStimulus();
        checkOutput("illegalAcqPulse", 32'(bus.protocolError), 32'h0);
        bus.toRecoveryPhase = 1'b1; bus.flushAllInsns = 1'b1;
        applyStimulus();

        // Reset while unit0 computes (counter 10) and unit1 is finished
        bus.acquire[1] = 1'b1; bus.acquireActiveListPtr[1] = 6'd3;
        applyStimulus();
        bus.start[1] = 1'b1;
        applyStimulus();
        idle(L - 1);
        bus.acquire[0] = 1'b1; bus.acquireActiveListPtr[0] = 6'd4;
        applyStimulus();
        bus.start[0] = 1'b1;
        applyStimulus();
        idle(23);
        checkOutput("preResetBusy", 32'(bus.busy), 32'h1);
        checkOutput("preResetFinished", 32'(bus.finished), 32'h2);
        rst = 1'b1; bus.acquire = 2'b11; bus.start = 2'b11;
        applyStimulus();
        checkOutput("midResetFree", 32'(bus.free), 32'h3);
        checkOutput("midResetBusy", 32'(bus.busy), 32'h0);
        checkOutput("midResetFinished", 32'(bus.finished), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NU; i++) begin
                bus.acquire[i]              = ($urandom_range(0, 3) == 0);
                bus.acquireActiveListPtr[i] = W'($urandom_range(0, 63));
                bus.start[i]                = ($urandom_range(0, 3) == 0);
                bus.releaseUnit[i]          = ($urandom_range(0, 2) == 0);
            end
            bus.toRecoveryPhase   = ($urandom_range(0, 29) == 0);
            bus.flushRangeHeadPtr = W'($urandom_range(0, 63));
            bus.flushRangeTailPtr = W'($urandom_range(0, 63));
            bus.flushAllInsns     = ($urandom_range(0, 3) == 0);
            rst                   = ($urandom_range(0, 999) == 0);
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
